// File: rtl/lc3b_types_pkg.sv
// Shared LC-3b types for the out-of-order core: reorder buffer entry layout,
// tag type and default geometry.
package lc3b_types;

    localparam int ROB_DEPTH      = 8;
    localparam int ROB_DATA_WIDTH = 16;
    localparam int ROB_REG_WIDTH  = 3;
    localparam int ROB_TAG_WIDTH  = $clog2(ROB_DEPTH);

    typedef logic [ROB_TAG_WIDTH-1:0] lc3b_rob_tag;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      has_dest;
        logic [ROB_REG_WIDTH-1:0]  dest;
        logic [ROB_DATA_WIDTH-1:0] data;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer feeding the architectural register file.
// Issue allocates at the tail, the CDB completes entries out of order, and the
// head retires one completed entry per cycle.
// Build option: ROB_CDB_BYPASS_EN lets the operand lookup see the CDB result
// of the current cycle; otherwise lookups see stored state only.
module reorder_buffer
    import lc3b_types::*;
#(
    parameter int DEPTH      = ROB_DEPTH,
    parameter int DATA_WIDTH = ROB_DATA_WIDTH,
    parameter int REG_WIDTH  = ROB_REG_WIDTH,
    localparam int TAG_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic                  alloc_has_dest,
    input  logic [REG_WIDTH-1:0]  alloc_dest,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,
    input  logic                  cdb_valid,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    input  logic [TAG_WIDTH-1:0]  rd_tag,
    output logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  commit_valid,
    output logic                  commit_load,
    output logic [REG_WIDTH-1:0]  commit_dest,
    output logic [DATA_WIDTH-1:0] commit_data,
    output logic [TAG_WIDTH-1:0]  commit_tag,
    input  logic                  flush,
    output logic                  full,
    output logic                  empty
);

    localparam logic [TAG_WIDTH:0]   FULL_COUNT = DEPTH[TAG_WIDTH:0];
    localparam logic [TAG_WIDTH-1:0] TAG_ONE    = {{(TAG_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TAG_WIDTH:0]   CNT_ONE    = {{TAG_WIDTH{1'b0}}, 1'b1};

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [DEPTH-1:0]      done_q, done_d;
    logic [TAG_WIDTH-1:0]  head_q, head_d;
    logic [TAG_WIDTH-1:0]  tail_q, tail_d;
    logic [TAG_WIDTH:0]    count_q, count_d;

    // Payload storage is a flop array (multi-ported), never reset.
    logic                  has_dest_q [DEPTH];
    logic [REG_WIDTH-1:0]  dest_q     [DEPTH];
    logic [DATA_WIDTH-1:0] data_q     [DEPTH];

    logic alloc_fire;
    logic cdb_fire;

    // Status flags come only from the registered occupancy count.
    assign full        = (count_q == FULL_COUNT);
    assign empty       = (count_q == '0);
    assign alloc_ready = !full;
    assign alloc_tag   = tail_q;

    // Flush suppresses both allocation and result capture on its edge.
    assign alloc_fire = alloc_valid && !full && !flush;
    assign cdb_fire   = cdb_valid && valid_q[cdb_tag] && !flush;

    // Head retirement view; payload outputs are zero when nothing retires.
    always_comb begin
        commit_valid = valid_q[head_q] && done_q[head_q];
        commit_load  = commit_valid && has_dest_q[head_q];
        commit_dest  = commit_valid ? dest_q[head_q] : '0;
        commit_data  = commit_valid ? data_q[head_q] : '0;
        commit_tag   = commit_valid ? head_q : '0;
    end

    // Operand lookup by tag, optionally bypassing the live CDB.
    always_comb begin
        rd_ready = valid_q[rd_tag] && done_q[rd_tag];
        rd_data  = rd_ready ? data_q[rd_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_tag == rd_tag) && valid_q[rd_tag]) begin
            rd_ready = 1'b1;
            rd_data  = cdb_data;
        end
`endif
    end

    // Next-state for entry status bits, pointers and occupancy.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            // The head retirement on this edge still leaves through commit_*.
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (commit_valid) begin
                valid_d[head_q] = 1'b0;
                head_d          = head_q + TAG_ONE;
            end
            if (cdb_fire) begin
                done_d[cdb_tag] = 1'b1;
            end
            // The tail slot is never valid while allocation is allowed, so
            // this cannot collide with the CDB write above.
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                tail_d          = tail_q + TAG_ONE;
            end
            unique case ({alloc_fire, commit_valid})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payload capture at allocation and at writeback.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            has_dest_q[tail_q] <= alloc_has_dest;
            dest_q[tail_q]     <= alloc_dest;
        end
        if (cdb_fire) begin
            data_q[cdb_tag] <= cdb_data;
        end
    end

endmodule
